bitonic_merge8_seq: RTL and testbench
=====================================

// Module: bitonic_merge8_seq
// PURPOSE
//  Final merge end of the 8-input bitonic sorter. Consumes the bitonic sequence produced by the
//  sorter's second stage (elements 0-3 descending, 4-7 ascending) and produces a fully sorted vector.
//  Uses one time-shared compare-exchange unit over 3 passes x 4 pairs = 12 cycles.
//  Sits between the sorting network front end and result consumers, with valid/ready on both sides.
// PARAMETERS
//  DATA_W  8  element width, unsigned
//  ASCEND  1  1: element 0 = smallest; 0: element 0 = largest
// PORTS
//  clk        in   1         single clock; all logic on rising edge
//  reset      in   1         synchronous, active-high
//  in_valid   in   1         data_in holds a bitonic vector
//  in_ready   out  1         block can accept a vector (IDLE only)
//  data_in    in   8*DATA_W  element k at bits [k*DATA_W +: DATA_W]
//  out_valid  out  1         data_out holds the merged result
//  out_ready  in   1         consumer accepts data_out
//  data_out   out  8*DATA_W  merged vector, same packing as data_in
//  busy       out  1         high in MERGE or DONE
// BEHAVIOUR
//  - Reset values: in_ready=1 after reset, out_valid=0, busy=0, data_out=0, internal regs=0, state=IDLE.
//  - FSM states and transitions:
//    - IDLE -> MERGE on in_valid&&in_ready: 8 elements loaded into the working register, pass=0, pair=0.
//    - MERGE performs one compare-exchange per cycle. Distance d = 4,2,1 for pass 0,1,2.
//      For pair k (0..3): i = (k/d)*2d + k%d, j = i+d.
//      If ASCEND: swap when e[i] > e[j]; else swap when e[i] < e[j]. Strict compare, so equal values
//      never swap. Unsigned compare, no width growth.
//    - After the 12th exchange (pass=2, pair=3): MERGE -> DONE. data_out is written with the final
//      vector and out_valid=1 on that same edge.
//  - Latency: out_valid rises exactly 12 cycles after the accepting edge.
//  - DONE holds data_out and out_valid stable until out_valid&&out_ready, then goes to IDLE.
//    out_valid drops, data_out holds its last value.
//  - in_ready=1 only in IDLE. in_valid in other states is ignored, nothing is queued.
//  - Throughput: 14 cycles per vector with in_valid/out_ready tied high
//    (accept + 12 merge + DONE handshake).
//  - Non-bitonic input: output is the deterministic network result, not guaranteed sorted; no error flag.
//  - Reset mid-MERGE or in DONE: abort the transaction, back to reset values on the next edge, result
//    discarded.
//  - Counters pass (2b) and pair (2b) wrap to 0 on each load. pair wraps 3->0 with pass+1.
//    pass never exceeds 2.
// STRUCTURE
//  - Shared package bitonic_pkg: state encoding (IDLE/MERGE/DONE), N_ELEM=8, DIST table {4,2,1},
//    default DATA_W.
//  - One sub-module: bitonic_cmp_swap (combinational; a,b,ascend -> lo/hi per direction).
//    Reusable by the existing sorter stages.
//  - Index computation and element mux/demux live in this module. No memories.
// TESTING
//  - ASCEND=1, data_in e0..e7 = 90,70,40,10,20,30,60,80 -> data_out 10,20,30,40,60,70,80,90;
//    out_valid exactly 12 cycles after accept.
//  - ASCEND=0, same input -> 90,80,70,60,40,30,20,10.
//  - Duplicates 255,255,0,0,0,0,255,255 (ASCEND=1) -> 0,0,0,0,255,255,255,255; all-0x55 -> unchanged;
//    no X on outputs.
//  - Backpressure: hold out_ready=0 for 5 cycles in DONE -> data_out/out_valid stable, in_ready=0,
//    in_valid pulses ignored. Then out_ready=1 -> IDLE next edge.
//  - Reset asserted on the 6th MERGE cycle -> next edge out_valid=0, in_ready=1, data_out=0;
//    the following vector merges correctly.
//  - in_valid and out_ready tied high with 4 random bitonic vectors -> accepts spaced 14 cycles apart,
//    all outputs match the reference model.

Source files
------------

// File: rtl/bitonic_pkg.sv
`default_nettype none
// ============================================================================
// bitonic_pkg : shared types and constants for the bitonic sorter stages
// Revision    : 1.0
// ============================================================================
package bitonic_pkg;

    localparam int N_ELEM         = 8;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_DONE  = 2'd2
    } merge_state_t;

    // Compare distance per merge pass: 4, 2, 1.
    function automatic logic [2:0] merge_dist(input logic [1:0] pass);
        case (pass)
            2'd0:    merge_dist = 3'd4;
            2'd1:    merge_dist = 3'd2;
            default: merge_dist = 3'd1;
        endcase
    endfunction

    // Lower index of pair k in a pass: i = (k/d)*2d + k%d.
    function automatic logic [2:0] merge_lo_index(input logic [1:0] pass, input logic [1:0] pair);
        case (pass)
            2'd0:    merge_lo_index = {1'b0, pair};
            2'd1:    merge_lo_index = {pair[1], 1'b0, pair[0]};
            default: merge_lo_index = {pair, 1'b0};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitonic_cmp_swap.sv
`default_nettype none
// ============================================================================
// bitonic_cmp_swap : combinational compare-exchange, lo/hi ordered by direction
// Revision         : 1.0
// ============================================================================
module bitonic_cmp_swap #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ascend,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    logic w_swap;

    // Strict compare: equal operands keep their positions.
    assign w_swap = ascend ? (a > b) : (a < b);
    assign lo     = w_swap ? b : a;
    assign hi     = w_swap ? a : b;

endmodule
`default_nettype wire

// File: rtl/bitonic_merge8_seq.sv
`default_nettype none
// ============================================================================
// bitonic_merge8_seq : 8-element bitonic merge, one shared compare-exchange,
//                      3 passes x 4 pairs with valid/ready on both sides
// Revision           : 1.0
// ============================================================================
module bitonic_merge8_seq
    import bitonic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter bit ASCEND = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_ELEM*DATA_W-1:0] data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_ELEM*DATA_W-1:0] data_out,
    output logic                     busy
);

    merge_state_t              r_state;
    merge_state_t              w_state_nxt;
    logic [N_ELEM*DATA_W-1:0]  r_work;
    logic [N_ELEM*DATA_W-1:0]  w_work_nxt;
    logic [N_ELEM*DATA_W-1:0]  r_data_out;
    logic [1:0]                r_pass;
    logic [1:0]                r_pair;
    logic [2:0]                w_idx_i;
    logic [2:0]                w_idx_j;
    logic [DATA_W-1:0]         w_elem_i;
    logic [DATA_W-1:0]         w_elem_j;
    logic [DATA_W-1:0]         w_lo;
    logic [DATA_W-1:0]         w_hi;
    logic                      w_last;

    assign w_idx_i  = merge_lo_index(r_pass, r_pair);
    assign w_idx_j  = w_idx_i + merge_dist(r_pass);
    assign w_elem_i = r_work[int'(w_idx_i)*DATA_W +: DATA_W];
    assign w_elem_j = r_work[int'(w_idx_j)*DATA_W +: DATA_W];
    assign w_last   = (r_pass == 2'd2) && (r_pair == 2'd3);

    bitonic_cmp_swap #(
        .DATA_W (DATA_W)
    ) u_cmp_swap (
        .a      (w_elem_i),
        .b      (w_elem_j),
        .ascend (ASCEND),
        .lo     (w_lo),
        .hi     (w_hi)
    );

    always_comb begin
        w_work_nxt = r_work;
        w_work_nxt[int'(w_idx_i)*DATA_W +: DATA_W] = w_lo;
        w_work_nxt[int'(w_idx_j)*DATA_W +: DATA_W] = w_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_MERGE;
                end
            end
            ST_MERGE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_work     <= '0;
            r_data_out <= '0;
            r_pass     <= '0;
            r_pair     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work <= data_in;
                        r_pass <= '0;
                        r_pair <= '0;
                    end
                end
                ST_MERGE: begin
                    r_work <= w_work_nxt;
                    r_pair <= r_pair + 2'd1;
                    if (w_last) begin
                        r_pass     <= '0;
                        r_data_out <= w_work_nxt;
                    end else if (r_pair == 2'd3) begin
                        r_pass <= r_pass + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_bitonic_merge8_seq.sv
`default_nettype none
// ============================================================================
// tb_bitonic_merge8_seq : directed and streaming checks of the bitonic merger
// Revision              : 1.0
// ============================================================================
module tb_bitonic_merge8_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] data_in;
    logic        in_ready_a, out_valid_a, busy_a;
    logic [63:0] data_out_a;
    logic        in_ready_d, out_valid_d, busy_d;
    logic [63:0] data_out_d;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bitonic_merge8_seq #(.DATA_W(8), .ASCEND(1'b1)) dut_up (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .data_in(data_in), .out_valid(out_valid_a), .out_ready(out_ready),
        .data_out(data_out_a), .busy(busy_a)
    );

    bitonic_merge8_seq #(.DATA_W(8), .ASCEND(1'b0)) dut_dn (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_d),
        .data_in(data_in), .out_valid(out_valid_d), .out_ready(out_ready),
        .data_out(data_out_d), .busy(busy_d)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] vec8(input int a0, input int a1, input int a2, input int a3,
                                         input int a4, input int a5, input int a6, input int a7);
        return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Reference: plain bubble sort of the eight elements.
    function automatic logic [63:0] sort8(input logic [63:0] v, input bit asc);
        logic [7:0] e [8];
        logic [7:0] t;
        logic [63:0] r;
        for (int k = 0; k < 8; k++) e[k] = v[k*8 +: 8];
        for (int p = 0; p < 7; p++)
            for (int q = 0; q < 7 - p; q++)
                if (asc ? (e[q] > e[q+1]) : (e[q] < e[q+1])) begin
                    t = e[q]; e[q] = e[q+1]; e[q+1] = t;
                end
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = e[k];
        return r;
    endfunction

    task automatic run_vec(input string tag, input logic [63:0] v,
                           input logic [63:0] exp_up, input logic [63:0] exp_dn);
        int cnt;
        in_valid = 1'b1;
        data_in  = v;
        step();
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy_a), 64'd1);
        check({tag, "_in_ready_merge"}, 64'(in_ready_a), 64'd0);
        cnt = 0;
        while (!out_valid_a && cnt < 40) begin
            step();
            cnt++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'd12);
        check({tag, "_valid_dn"}, 64'(out_valid_d), 64'd1);
        check({tag, "_data_up"}, data_out_a, exp_up);
        check({tag, "_data_dn"}, data_out_d, exp_dn);
        check({tag, "_no_x"}, 64'($isunknown(data_out_a) || $isunknown(data_out_d)), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 64'(in_ready_a), 64'd1);
        check({tag, "_idle_valid"}, 64'(out_valid_a), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] va, va_up, va_dn, vdup, vdup_up, vdup_dn, v55;
        logic [63:0] s, rv [4];
        int          acc_cyc [4];
        int          cnt, cyc, acc, got;
        logic        accept_now;

        va      = vec8(90, 70, 40, 10, 20, 30, 60, 80);
        va_up   = vec8(10, 20, 30, 40, 60, 70, 80, 90);
        va_dn   = vec8(90, 80, 70, 60, 40, 30, 20, 10);
        vdup    = vec8(255, 255, 0, 0, 0, 0, 255, 255);
        vdup_up = vec8(0, 0, 0, 0, 255, 255, 255, 255);
        vdup_dn = vec8(255, 255, 255, 255, 0, 0, 0, 0);
        v55     = 64'h5555_5555_5555_5555;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        repeat (3) step();
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready_a), 64'd1);
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_data_out", data_out_a, 64'd0);

        run_vec("vecA", va, va_up, va_dn);
        run_vec("dup", vdup, vdup_up, vdup_dn);
        run_vec("all55", v55, v55, v55);

        // Backpressure in DONE with stray in_valid pulses.
        in_valid = 1'b1;
        data_in  = va;
        step();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid_a && cnt < 40) begin
            step();
            cnt++;
        end
        check("bp_latency", 64'(cnt), 64'd12);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            data_in  = vdup;
            step();
            check("bp_data", data_out_a, va_up);
            check("bp_valid", 64'(out_valid_a), 64'd1);
            check("bp_in_ready", 64'(in_ready_a), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid_a), 64'd0);
        check("bp_release_ready", 64'(in_ready_a), 64'd1);
        check("bp_hold_data", data_out_a, va_up);
        step();
        check("bp_not_queued", 64'(busy_a), 64'd0);

        // Reset during the 6th merge cycle.
        in_valid = 1'b1;
        data_in  = vdup;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_valid", 64'(out_valid_a), 64'd0);
        check("abort_ready", 64'(in_ready_a), 64'd1);
        check("abort_data", data_out_a, 64'd0);
        check("abort_busy", 64'(busy_a), 64'd0);
        run_vec("post_abort", va, va_up, va_dn);

        // Streaming with in_valid and out_ready tied high.
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 8; k++) s[k*8 +: 8] = 8'($urandom_range(0, 255));
            s = sort8(s, 1'b0);
            rv[n] = {s[8*1 +: 8], s[8*3 +: 8], s[8*5 +: 8], s[8*7 +: 8],
                     s[8*6 +: 8], s[8*4 +: 8], s[8*2 +: 8], s[8*0 +: 8]};
        end
        cyc = 0; acc = 0; got = 0;
        data_in   = rv[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (got < 4 && cyc < 200) begin
            accept_now = in_ready_a && in_valid;
            if (out_valid_a) begin
                check("stream_up", data_out_a, sort8(rv[got], 1'b1));
                check("stream_dn", data_out_d, sort8(rv[got], 1'b0));
                got++;
            end
            step();
            cyc++;
            if (accept_now) begin
                acc_cyc[acc] = cyc;
                acc++;
                if (acc < 4) data_in = rv[acc];
                else         in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_count", 64'(got), 64'd4);
        check("stream_accepts", 64'(acc), 64'd4);
        for (int k = 1; k < 4; k++)
            if (k < acc) check("stream_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
